// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR coefficient loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

  // Register map and limits of the FIR register port
  localparam logic [7:0] FIR_CTRL_ADDR = 8'hff;
  localparam int         FIR_MAX_LEN   = 255;
  localparam int         FIR_TIMEOUT   = 64;

  // Control word field positions
  localparam int BYPASS_BIT = 20;
  localparam int SHIFT_LSB  = 16;
  localparam int TAP_LSB    = 8;
  localparam int DS_LSB     = 0;

  typedef struct packed {
    logic       bypass;
    logic [3:0] shift;
    logic [7:0] tap_len;
    logic [7:0] down_sample;
  } ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUTE,
    ST_FETCH,
    ST_WR,
`ifdef FIR_COEF_VERIFY_EN
    ST_VERIFY,
`endif
    ST_CTRL,
    ST_DONE,
    ST_ERR
  } state_t;

  // Place control fields in a 32-bit register word; force_bypass mutes all channels.
  function automatic logic [31:0] ctrl_word(input ctrl_t c, input logic force_bypass);
    logic [31:0] w;
    w                   = '0;
    w[BYPASS_BIT]       = c.bypass | force_bypass;
    w[SHIFT_LSB +: 4]   = c.shift;
    w[TAP_LSB +: 8]     = c.tap_len;
    w[DS_LSB +: 8]      = c.down_sample;
    return w;
  endfunction

endpackage

// File: rtl/fir_reg_master.sv
// fir_reg_master: performs one FIR register read or write per start pulse.
// Latency: strobe rises the cycle after start; ack/timeout pulses the cycle after reg_ready=1 or the TIMEOUT-th wait cycle.
// Backpressure: start is ignored while an access is in flight; the strobe always drops after completion.
module fir_reg_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_reg_wr,
  output logic        o_reg_rd,
  output logic [7:0]  o_reg_addr,
  output logic [31:0] o_reg_writedata,
  input  logic        i_reg_ready,
  input  logic [31:0] i_reg_readdata,
  output logic        o_ack,
  output logic        o_timeout,
  output logic [31:0] o_rdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic          r_wr;
  logic          r_rd;
  logic          r_ack;
  logic          r_timeout;
  logic [7:0]    r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_active;

  assign w_active = r_wr | r_rd;

  // Launch an access, wait for reg_ready, then drop the strobe; give up after TIMEOUT strobe cycles.
  always_ff @(posedge clk_2) begin
    if (rst) begin
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
      if (w_active) begin
        if (i_reg_ready) begin
          r_wr    <= 1'b0;
          r_rd    <= 1'b0;
          r_ack   <= 1'b1;
          r_rdata <= i_reg_readdata;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          r_wr      <= 1'b0;
          r_rd      <= 1'b0;
          r_timeout <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (i_start) begin
        r_wr    <= i_we;
        r_rd    <= ~i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= '0;
      end
    end
  end

  assign o_reg_wr        = r_wr;
  assign o_reg_rd        = r_rd;
  assign o_reg_addr      = r_addr;
  assign o_reg_writedata = r_wdata;
  assign o_ack           = r_ack;
  assign o_timeout       = r_timeout;
  assign o_rdata         = r_rdata;

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: loads a coefficient stream into the FIR parameter RAM, muting channels while taps change.
// Latency: >= 3 clk_2 cycles per register access, plus coefficient fetch time; done pulses after the final control write.
// Backpressure: cmd_ready only in IDLE (no queueing); coef_ready pulses once per accepted word, only in FETCH.
// Option: define FIR_COEF_VERIFY_EN to read the taps back and compare an XOR signature before un-muting.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter logic [7:0] CTRL_ADDR = FIR_CTRL_ADDR,
  parameter int         MAX_LEN   = FIR_MAX_LEN,
  parameter int         TIMEOUT   = FIR_TIMEOUT
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_len,
  input  logic [20:0] i_cmd_ctrl,
  input  logic        i_coef_valid,
  output logic        o_coef_ready,
  input  logic [31:0] i_coef_data,
  output logic [7:0]  o_reg_addr,
  output logic        o_reg_wr,
  output logic        o_reg_rd,
  output logic [31:0] o_reg_writedata,
  input  logic        i_reg_ready,
  input  logic [31:0] i_reg_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_err_addr
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_len;
  logic [7:0]  r_idx;
  ctrl_t       r_ctrl;
  logic [31:0] r_coef;
  logic        r_err;
  logic [7:0]  r_err_addr;
  logic        r_issued;

  logic        w_start;
  logic        w_we;
  logic [7:0]  w_addr;
  logic [31:0] w_wdata;
  logic        w_ack;
  logic        w_tmo;
  logic [31:0] w_rdata;
  logic        w_rd;
  logic        w_last;
  logic        w_len_bad;
  logic        w_err_load;
  logic [7:0]  w_err_addr;

  assign w_last    = (r_idx == r_len - 8'd1);
  assign w_len_bad = (i_cmd_len == 8'd0) || ({1'b0, i_cmd_len} > 9'(MAX_LEN));

`ifdef FIR_COEF_VERIFY_EN
  logic [31:0] r_wxor;
  logic [31:0] r_rxor;
  logic        w_match;
  // Signature is complete once the last readback word is folded in.
  assign w_match = ((r_rxor ^ w_rdata) == r_wxor);
`endif

  fir_reg_master #(
    .TIMEOUT(TIMEOUT)
  ) u_master (
    .clk_2          (clk_2),
    .rst            (rst),
    .i_start        (w_start),
    .i_we           (w_we),
    .i_addr         (w_addr),
    .i_wdata        (w_wdata),
    .o_reg_wr       (o_reg_wr),
    .o_reg_rd       (w_rd),
    .o_reg_addr     (o_reg_addr),
    .o_reg_writedata(o_reg_writedata),
    .i_reg_ready    (i_reg_ready),
    .i_reg_readdata (i_reg_readdata),
    .o_ack          (w_ack),
    .o_timeout      (w_tmo),
    .o_rdata        (w_rdata)
  );

`ifdef FIR_COEF_VERIFY_EN
  assign o_reg_rd = w_rd;
`else
  logic w_unused_rd;
  assign o_reg_rd    = 1'b0;
  assign w_unused_rd = ^{w_rd, w_rdata};
`endif

  // State register
  always_ff @(posedge clk_2) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, access requests and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_we         = 1'b1;
    w_addr       = CTRL_ADDR;
    w_wdata      = '0;
    w_err_load   = 1'b0;
    w_err_addr   = CTRL_ADDR;
    o_cmd_ready  = 1'b0;
    o_coef_ready = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (w_len_bad) begin
            w_state_nxt = ST_ERR;
            w_err_load  = 1'b1;
          end else begin
            w_state_nxt = ST_MUTE;
          end
        end
      end
      ST_MUTE: begin
        w_start = ~r_issued;
        w_wdata = ctrl_word(r_ctrl, 1'b1);
        if (w_tmo) begin
          w_state_nxt = ST_ERR;
          w_err_load  = 1'b1;
        end else if (w_ack) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_coef_ready = i_coef_valid;
        if (i_coef_valid) begin
          w_state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        w_start = ~r_issued;
        w_addr  = r_idx;
        w_wdata = r_coef;
        if (w_tmo) begin
          w_state_nxt = ST_ERR;
          w_err_load  = 1'b1;
          w_err_addr  = r_idx;
        end else if (w_ack) begin
`ifdef FIR_COEF_VERIFY_EN
          w_state_nxt = w_last ? ST_VERIFY : ST_FETCH;
`else
          w_state_nxt = w_last ? ST_CTRL : ST_FETCH;
`endif
        end
      end
`ifdef FIR_COEF_VERIFY_EN
      ST_VERIFY: begin
        w_start = ~r_issued;
        w_we    = 1'b0;
        w_addr  = r_idx;
        if (w_tmo) begin
          w_state_nxt = ST_ERR;
          w_err_load  = 1'b1;
          w_err_addr  = r_idx;
        end else if (w_ack && w_last) begin
          if (w_match) begin
            w_state_nxt = ST_CTRL;
          end else begin
            w_state_nxt = ST_ERR;
            w_err_load  = 1'b1;
            w_err_addr  = r_len - 8'd1;
          end
        end
      end
`endif
      ST_CTRL: begin
        w_start = ~r_issued;
        w_wdata = ctrl_word(r_ctrl, 1'b0);
        if (w_tmo) begin
          w_state_nxt = ST_ERR;
          w_err_load  = 1'b1;
        end else if (w_ack) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, tap index, coefficient holding register and error reporting
  always_ff @(posedge clk_2) begin
    if (rst) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_ctrl     <= '0;
      r_coef     <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_issued   <= 1'b0;
`ifdef FIR_COEF_VERIFY_EN
      r_wxor     <= '0;
      r_rxor     <= '0;
`endif
    end else begin
      if (w_start) begin
        r_issued <= 1'b1;
      end else if (w_ack || w_tmo) begin
        r_issued <= 1'b0;
      end
      if (w_err_load) begin
        r_err_addr <= w_err_addr;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_len  <= i_cmd_len;
            r_ctrl <= i_cmd_ctrl;
            r_err  <= 1'b0;
`ifdef FIR_COEF_VERIFY_EN
            r_wxor <= '0;
            r_rxor <= '0;
`endif
          end
        end
        ST_MUTE: begin
          if (w_ack) begin
            r_idx <= '0;
          end
        end
        ST_FETCH: begin
          if (i_coef_valid) begin
            r_coef <= i_coef_data;
          end
        end
        ST_WR: begin
          if (w_ack) begin
            r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
`ifdef FIR_COEF_VERIFY_EN
            r_wxor <= r_wxor ^ r_coef;
`endif
          end
        end
`ifdef FIR_COEF_VERIFY_EN
        ST_VERIFY: begin
          if (w_ack) begin
            r_idx  <= r_idx + 8'd1;
            r_rxor <= r_rxor ^ w_rdata;
          end
        end
`endif
        ST_ERR: begin
          r_err <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_err      = r_err;
  assign o_err_addr = r_err_addr;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: randomized loads against a queue-based model of the expected FIR bus traffic.
// Latency: n/a (testbench).
// Backpressure: coefficient source inserts random idle cycles; FIR responder toggles reg_ready while strobed.
module tb_fir_coef_loader;

  localparam int TIMEOUT = 64;

  logic        clk_2 = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_len = '0;
  logic [20:0] i_cmd_ctrl = '0;
  logic        i_coef_valid = 1'b0;
  logic        o_coef_ready;
  logic [31:0] i_coef_data = '0;
  logic [7:0]  o_reg_addr;
  logic        o_reg_wr;
  logic        o_reg_rd;
  logic [31:0] o_reg_writedata;
  logic        i_reg_ready = 1'b0;
  logic [31:0] i_reg_readdata = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_err_addr;

  fir_coef_loader dut (
    .clk_2          (clk_2),
    .rst            (rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_len      (i_cmd_len),
    .i_cmd_ctrl     (i_cmd_ctrl),
    .i_coef_valid   (i_coef_valid),
    .o_coef_ready   (o_coef_ready),
    .i_coef_data    (i_coef_data),
    .o_reg_addr     (o_reg_addr),
    .o_reg_wr       (o_reg_wr),
    .o_reg_rd       (o_reg_rd),
    .o_reg_writedata(o_reg_writedata),
    .i_reg_ready    (i_reg_ready),
    .i_reg_readdata (i_reg_readdata),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_err_addr     (o_err_addr)
  );

  always #5 clk_2 = ~clk_2;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] coef_q[$];
  logic [31:0] exp_coef[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  rd_addr_q[$];
  logic [31:0] mem[256];
  bit          want_cmd = 1'b0;
  bit          hold_coef = 1'b0;
  bit          resp_seen = 1'b0;
  bit          gap_pending = 1'b0;
  bit          stall_en = 1'b0;
  logic [7:0]  stall_addr = '0;
  int          stall_cycles = 0;
  bit          corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = '0;
  int          done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: the muted control word is the command word with bit 20 forced on.
  function automatic logic [31:0] mute_of(input logic [20:0] c);
    return {11'd0, c} | 32'h0010_0000;
  endfunction

  // One clock cycle: FIR responder, bus monitor and stimulus, all sampled at the falling edge.
  task automatic tick();
    logic strobe;
    @(negedge clk_2);
    strobe = o_reg_wr | o_reg_rd;
    if (gap_pending) check_eq("strobe_gap", {31'd0, strobe}, 32'd0);
    gap_pending = 1'b0;
    if (!strobe) begin
      i_reg_ready = 1'b0;
      resp_seen   = 1'b0;
    end else if (!resp_seen) begin
      i_reg_ready = 1'b0;
      resp_seen   = 1'b1;
    end else begin
      i_reg_ready = ~i_reg_ready;
    end
    if (stall_en && strobe && o_reg_addr == stall_addr) begin
      i_reg_ready = 1'b0;
      stall_cycles++;
    end
    if (strobe && i_reg_ready) begin
      gap_pending = 1'b1;
      if (o_reg_wr) begin
        wr_addr_q.push_back(o_reg_addr);
        wr_data_q.push_back(o_reg_writedata);
        mem[o_reg_addr] = o_reg_writedata;
      end else begin
        rd_addr_q.push_back(o_reg_addr);
        i_reg_readdata = mem[o_reg_addr] ^ ((corrupt_en && o_reg_addr == corrupt_addr) ? 32'h0000_0100 : 32'h0);
      end
    end
    if (o_done) done_cnt++;
    i_cmd_valid = want_cmd;
    if (!hold_coef && coef_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      i_coef_valid = 1'b1;
      i_coef_data  = coef_q[0];
    end else begin
      i_coef_valid = 1'b0;
      i_coef_data  = $urandom;
    end
    #1;
    if (i_cmd_valid && o_cmd_ready) want_cmd = 1'b0;
    if (i_coef_valid && o_coef_ready) void'(coef_q.pop_front());
  endtask

  task automatic rand_coefs(input int n);
    exp_coef.delete();
    for (int i = 0; i < n; i++) exp_coef.push_back($urandom);
  endtask

  task automatic start_load(input string tag, input logic [7:0] len, input logic [20:0] ctrl);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    done_cnt   = 0;
    coef_q     = exp_coef;
    i_cmd_len  = len;
    i_cmd_ctrl = ctrl;
    want_cmd   = 1'b1;
    for (int i = 0; i < 20 && want_cmd; i++) tick();
    check_eq({tag, "_accept"}, {31'd0, want_cmd}, 32'd0);
    want_cmd = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(o_cmd_ready && (done_cnt > 0 || o_err)) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_finished"}, {31'd0, n < budget}, 32'd1);
    tick();
    tick();
  endtask

  task automatic check_writes(input string tag, input int nw, input logic [20:0] ctrl, input bit with_final);
    int exp_n;
    exp_n = 1 + nw + (with_final ? 1 : 0);
    check_eq({tag, "_nwr"}, wr_addr_q.size(), exp_n);
    if (wr_addr_q.size() == exp_n) begin
      check_eq({tag, "_mute_a"}, {24'd0, wr_addr_q[0]}, 32'h0000_00ff);
      check_eq({tag, "_mute_d"}, wr_data_q[0], mute_of(ctrl));
      for (int i = 0; i < nw; i++) begin
        check_eq({tag, "_tap_a"}, {24'd0, wr_addr_q[1+i]}, i);
        check_eq({tag, "_tap_d"}, wr_data_q[1+i], exp_coef[i]);
      end
      if (with_final) begin
        check_eq({tag, "_ctrl_a"}, {24'd0, wr_addr_q[exp_n-1]}, 32'h0000_00ff);
        check_eq({tag, "_ctrl_d"}, wr_data_q[exp_n-1], {11'd0, ctrl});
      end
    end
  endtask

  task automatic finish_ok(input string tag, input int len, input logic [20:0] ctrl);
    check_writes(tag, len, ctrl, 1'b1);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_err"}, {31'd0, o_err}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
`ifdef FIR_COEF_VERIFY_EN
    check_eq({tag, "_nrd"}, rd_addr_q.size(), len);
    if (rd_addr_q.size() == len) begin
      for (int i = 0; i < len; i++) check_eq({tag, "_rd_a"}, {24'd0, rd_addr_q[i]}, i);
    end
`else
    check_eq({tag, "_nrd"}, rd_addr_q.size(), 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, {31'd0, o_cmd_ready}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, o_err}, 32'd0);
    check_eq({tag, "_err_addr"}, {24'd0, o_err_addr}, 32'd0);
    check_eq({tag, "_wr"}, {31'd0, o_reg_wr}, 32'd0);
    check_eq({tag, "_rd"}, {31'd0, o_reg_rd}, 32'd0);
    check_eq({tag, "_addr"}, {24'd0, o_reg_addr}, 32'd0);
    check_eq({tag, "_wdata"}, o_reg_writedata, 32'd0);
    check_eq({tag, "_coef_ready"}, {31'd0, o_coef_ready}, 32'd0);
  endtask

  initial begin
    logic [20:0] ctrl;
    int          len;
    int          n;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Directed load: four known taps
    exp_coef = '{32'h11, 32'h22, 32'h33, 32'h44};
    start_load("t1", 8'd4, 21'h09_0401);
    wait_end("t1", 400);
    finish_ok("t1", 4, 21'h09_0401);

    // Coefficient source goes quiet mid-stream
    rand_coefs(5);
    ctrl = 21'($urandom);
    start_load("t2", 8'd5, ctrl);
    n = 0;
    while (wr_addr_q.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    hold_coef = 1'b1;
    repeat (10) tick();
    check_eq("t2_hold_wr", {31'd0, o_reg_wr}, 32'd0);
    check_eq("t2_hold_busy", {31'd0, o_busy}, 32'd1);
    check_eq("t2_hold_nwr_le4", {31'd0, wr_addr_q.size() <= 4}, 32'd1);
    hold_coef = 1'b0;
    wait_end("t2", 400);
    finish_ok("t2", 5, ctrl);

    // FIR never answers on address 2
    rand_coefs(5);
    ctrl         = 21'($urandom);
    stall_en     = 1'b1;
    stall_addr   = 8'd2;
    stall_cycles = 0;
    start_load("t3", 8'd5, ctrl);
    wait_end("t3", 600);
    check_eq("t3_err", {31'd0, o_err}, 32'd1);
    check_eq("t3_err_addr", {24'd0, o_err_addr}, 32'd2);
    check_eq("t3_stall_cycles", stall_cycles, TIMEOUT);
    check_eq("t3_done_cnt", done_cnt, 0);
    check_eq("t3_busy", {31'd0, o_busy}, 32'd0);
    check_writes("t3", 2, ctrl, 1'b0);
    stall_en = 1'b0;
    coef_q.delete();

    // Zero-length command is rejected, next command clears the error
    exp_coef.delete();
    start_load("t4", 8'd0, 21'h1F_FFFF);
    wait_end("t4", 50);
    check_eq("t4_err", {31'd0, o_err}, 32'd1);
    check_eq("t4_err_addr", {24'd0, o_err_addr}, 32'h0000_00ff);
    check_eq("t4_nwr", wr_addr_q.size(), 0);
    check_eq("t4_done_cnt", done_cnt, 0);
    rand_coefs(3);
    ctrl = 21'($urandom);
    start_load("t4b", 8'd3, ctrl);
    tick();
    check_eq("t4b_err_cleared", {31'd0, o_err}, 32'd0);
    wait_end("t4b", 400);
    finish_ok("t4b", 3, ctrl);

    // Reset during the third tap write
    rand_coefs(6);
    ctrl = 21'($urandom);
    start_load("t5", 8'd6, ctrl);
    n = 0;
    while (!(o_reg_wr && o_reg_addr == 8'd2) && n < 300) begin
      tick();
      n++;
    end
    check_eq("t5_reached_wr2", {31'd0, n < 300}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_rst");
    check_eq("t5_nwr", wr_addr_q.size(), 3);
    tick();
    rst = 1'b0;
    coef_q.delete();
    tick();

    // Randomized loads including the length boundaries
    for (int k = 0; k < 8; k++) begin
      if (k == 0) len = 1;
      else if (k == 1) len = 255;
      else len = $urandom_range(1, 16);
      ctrl = 21'($urandom);
      rand_coefs(len);
      start_load("rnd", 8'(len), ctrl);
      wait_end("rnd", 20 * len + 300);
      finish_ok("rnd", len, ctrl);
    end

`ifdef FIR_COEF_VERIFY_EN
    // Corrupted readback on address 1
    rand_coefs(4);
    ctrl         = 21'($urandom);
    corrupt_en   = 1'b1;
    corrupt_addr = 8'd1;
    start_load("t6", 8'd4, ctrl);
    wait_end("t6", 600);
    check_eq("t6_err", {31'd0, o_err}, 32'd1);
    check_eq("t6_err_addr", {24'd0, o_err_addr}, 32'd3);
    check_eq("t6_done_cnt", done_cnt, 0);
    check_writes("t6", 4, ctrl, 1'b0);
    corrupt_en = 1'b0;
    rand_coefs(4);
    ctrl = 21'($urandom);
    start_load("t6b", 8'd4, ctrl);
    wait_end("t6b", 600);
    finish_ok("t6b", 4, ctrl);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
